// File: rtl/tdm_slot_if.sv
// Lane request and TDM channel bundle between requesters, scheduler and channel consumer.
// The master side drives the requests and the consumer ready. The slave side is the scheduler.
interface tdm_slot_if #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 2,
  parameter int SEL_W     = 2
);
  logic                        mode;
  logic [NUM_LANES-1:0]        lane_en;
  logic [NUM_LANES-1:0]        in_valid;
  logic [NUM_LANES*DATA_W-1:0] in_data;
  logic [NUM_LANES-1:0]        in_ready;
  logic                        out_valid;
  logic [DATA_W-1:0]           out_data;
  logic [SEL_W-1:0]            out_lane;
  logic                        out_ready;
  logic                        frame_start;

  modport master (
    output mode, lane_en, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_lane, frame_start
  );

  modport slave (
    input  mode, lane_en, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_lane, frame_start
  );
endinterface

// File: rtl/tdm_slot_scheduler.sv
// Shares one TDM channel between lanes, in either fixed-slot or work-conserving round-robin mode.
// Latency is one cycle from lane accept to out_data. With out_ready low and a full output, all in_ready bits drop and the output holds.
module tdm_slot_scheduler #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 2,
  parameter int SEL_W     = 2
) (
  input logic       clk,
  input logic       rst,
  tdm_slot_if.slave bus
);

  logic [SEL_W-1:0]  ptr;
  logic [DATA_W-1:0] lane_dat [NUM_LANES];
  logic              load;
  logic              found;
  logic [SEL_W-1:0]  grant;
  logic [SEL_W-1:0]  idx;
  logic [SEL_W:0]    sum;

  function automatic logic [SEL_W-1:0] next_lane(input logic [SEL_W-1:0] l);
    return (l == SEL_W'(NUM_LANES - 1)) ? '0 : l + 1'b1;
  endfunction

  always_comb begin
    load  = !bus.out_valid || bus.out_ready;
    found = 1'b0;
    grant = ptr;
    idx   = '0;
    sum   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_dat[i] = bus.in_data[i*DATA_W +: DATA_W];
    end
    if (!bus.mode) begin
      found = bus.lane_en[ptr] && bus.in_valid[ptr];
    end else begin
      // Scan starts at ptr and wraps explicitly so non-power-of-2 lane counts stay in range.
      for (int k = 0; k < NUM_LANES; k++) begin
        sum = {1'b0, ptr} + (SEL_W+1)'(k);
        idx = (sum >= (SEL_W+1)'(NUM_LANES)) ? SEL_W'(sum - (SEL_W+1)'(NUM_LANES))
                                             : sum[SEL_W-1:0];
        if (!found && bus.lane_en[idx] && bus.in_valid[idx]) begin
          found = 1'b1;
          grant = idx;
        end
      end
    end
    bus.in_ready = '0;
    if (rst && load && found) begin
      bus.in_ready[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr             <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_lane    <= '0;
      bus.frame_start <= 1'b0;
    end else if (load) begin
      bus.out_valid   <= found;
      bus.frame_start <= !bus.mode && (ptr == '0);
      if (found) begin
        bus.out_data <= lane_dat[grant];
      end
      // Fixed mode burns the slot even when empty; round-robin only moves on a grant.
      if (!bus.mode) begin
        bus.out_lane <= ptr;
        ptr          <= next_lane(ptr);
      end else if (found) begin
        bus.out_lane <= grant;
        ptr          <= next_lane(grant);
      end
    end
  end

endmodule

// File: tb/tb_tdm_slot_scheduler.sv
// Randomized and directed bench for tdm_slot_scheduler against a slot-level reference model and payload scoreboard.
module tb_tdm_slot_scheduler;
  localparam int N  = 4;
  localparam int DW = 2;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tdm_slot_if #(.NUM_LANES(N), .DATA_W(DW), .SEL_W(SW)) bus ();

  tdm_slot_scheduler #(.NUM_LANES(N), .DATA_W(DW), .SEL_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: what the channel should be showing after each edge.
  int m_ptr = 0, m_vld = 0, m_dat = 0, m_lane = 0, m_fs = 0;
  int sb_q[$];
  int accepted = 0, emitted = 0, discarded = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lane_data(input int l);
    return int'((bus.in_data >> (l * DW)) & ((1 << DW) - 1));
  endfunction

  task automatic step();
    int n_ptr, n_vld, n_dat, n_lane, n_fs, e_rdy, g, l;
    #2;
    n_ptr = m_ptr; n_vld = m_vld; n_dat = m_dat; n_lane = m_lane; n_fs = m_fs; e_rdy = 0;
    if (!rst) begin
      n_ptr = 0; n_vld = 0; n_dat = 0; n_lane = 0; n_fs = 0;
    end else if (!m_vld || bus.out_ready) begin
      if (!bus.mode) begin
        n_lane = m_ptr;
        n_ptr  = (m_ptr + 1) % N;
        n_fs   = (m_ptr == 0);
        n_vld  = 0;
        if (bus.lane_en[m_ptr] && bus.in_valid[m_ptr]) begin
          e_rdy = 1 << m_ptr;
          n_vld = 1;
          n_dat = lane_data(m_ptr);
        end
      end else begin
        g = -1;
        for (int k = 0; k < N; k++) begin
          l = (m_ptr + k) % N;
          if (g < 0 && bus.lane_en[l] && bus.in_valid[l]) g = l;
        end
        n_fs  = 0;
        n_vld = 0;
        if (g >= 0) begin
          e_rdy  = 1 << g;
          n_vld  = 1;
          n_dat  = lane_data(g);
          n_lane = g;
          n_ptr  = (g + 1) % N;
        end
      end
    end
    chk("in_ready", int'(bus.in_ready), e_rdy);

    if (!rst) begin
      discarded += sb_q.size();
      sb_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        emitted++;
        chk("sb_nonempty", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) chk("sb_payload", int'(bus.out_data), sb_q.pop_front());
      end
      for (int i = 0; i < N; i++) begin
        if (bus.in_valid[i] && bus.in_ready[i]) begin
          accepted++;
          sb_q.push_back(lane_data(i));
        end
      end
    end

    @(posedge clk);
    m_ptr = n_ptr; m_vld = n_vld; m_dat = n_dat; m_lane = n_lane; m_fs = n_fs;
    #1;
    chk("out_valid",   int'(bus.out_valid),   m_vld);
    chk("out_lane",    int'(bus.out_lane),    m_lane);
    chk("frame_start", int'(bus.frame_start), m_fs);
    if (m_vld != 0) chk("out_data", int'(bus.out_data), m_dat);
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) step();
  endtask

  initial begin
    bus.mode      = 1'b0;
    bus.lane_en   = 4'hF;
    bus.in_valid  = 4'hF;
    bus.in_data   = 8'b11_10_01_00;
    bus.out_ready = 1'b1;

    // Reset held with all lanes requesting.
    rst = 1'b0;
    run(3);
    chk("reset_out_data", int'(bus.out_data), 0);

    // Fixed mode, everyone valid: 0,1,2,3 with frame_start on lane 0.
    rst = 1'b1;
    run(8);

    // Fixed mode, only lane 2 requests: three empty slots per frame.
    bus.in_valid = 4'b0100;
    run(8);

    // Round-robin with lanes 1 and 3 requesting.
    bus.mode     = 1'b1;
    bus.in_valid = 4'b1010;
    run(8);

    // Backpressure mid-stream.
    bus.in_valid  = 4'hF;
    run(2);
    bus.out_ready = 1'b0;
    run(3);
    bus.out_ready = 1'b1;
    run(4);

    // Lane 2 disabled, then a one-cycle reset pulse.
    bus.lane_en = 4'b1011;
    run(8);
    rst = 1'b0;
    run(1);
    rst = 1'b1;
    run(6);

    // Fixed mode with a disabled lane: its slot stays empty.
    bus.mode = 1'b0;
    run(8);

    // Randomized traffic, mode flips, enables, backpressure and rare resets.
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 19) == 0) bus.mode = ~bus.mode;
      if ($urandom_range(0, 9) == 0) bus.lane_en = 4'($urandom);
      bus.in_valid  = 4'($urandom);
      bus.in_data   = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    chk("conservation", accepted, emitted + discarded + sb_q.size());
    chk("traffic_seen", int'(emitted > 100), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
